// File: rtl/axis_stream_sink_checker.sv
// AXI4-Stream sink: FWFT FIFO with a read port plus a packet-format checker
// (word k == k+1, TLAST on word PKT_WORDS-1) keeping saturating statistics.
module axis_stream_sink_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 8,
  parameter int PKT_WORDS            = 8
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic                                S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  input  logic                                rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
  output logic                                rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic [15:0]                         pkt_count,
  output logic [15:0]                         err_count,
  output logic                                err_seq,
  output logic                                err_len,
  input  logic                                clr_err
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_WORDS - 1);

  typedef enum logic {WAIT_FIRST, IN_PKT} state_e;

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          tready_q;
  logic          accept, pop;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [15:0]   pkt_count_q, err_count_q;
  logic          err_seq_q, err_len_q;
  logic          at_last, close_pkt, seq_err, len_err;
  logic [W-1:0]  exp_data;

  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign accept = S_AXIS_TVALID && tready_q;
  assign pop    = rd_en && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (accept) mem_q[wr_ptr_q] <= S_AXIS_TDATA;
  end

  // TREADY is held low through reset and comes up from the next-state occupancy.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_d;
      tready_q <= (count_d != FULL_CNT);
    end
  end

  assign at_last   = (idx_q == LAST_IDX);
  assign close_pkt = S_AXIS_TLAST || at_last;
  assign exp_data  = W'(idx_q) + W'(1);
  assign seq_err   = accept && (S_AXIS_TDATA != exp_data);
  assign len_err   = accept && (S_AXIS_TLAST != at_last);

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q     <= WAIT_FIRST;
      idx_q       <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      err_seq_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (close_pkt) begin
          state_q <= WAIT_FIRST;
          idx_q   <= '0;
        end else begin
          state_q <= IN_PKT;
          idx_q   <= idx_q + IW'(1);
        end
        if (S_AXIS_TLAST && (pkt_count_q != '1)) pkt_count_q <= pkt_count_q + 16'd1;
      end
      // A clear in the same cycle as an error restarts the statistics from that beat.
      if (seq_err || len_err) begin
        if (clr_err)                  err_count_q <= 16'd1;
        else if (err_count_q != '1)   err_count_q <= err_count_q + 16'd1;
        err_seq_q <= (err_seq_q && !clr_err) || seq_err;
        err_len_q <= (err_len_q && !clr_err) || len_err;
      end else if (clr_err) begin
        err_count_q <= '0;
        err_seq_q   <= 1'b0;
        err_len_q   <= 1'b0;
      end
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign rd_valid      = (count_q != '0);
  assign rd_data       = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count    = count_q;
  assign pkt_count     = pkt_count_q;
  assign err_count     = err_count_q;
  assign err_seq       = err_seq_q;
  assign err_len       = err_len_q;

endmodule

// File: tb/tb_axis_stream_sink_checker.sv
// Randomised and directed bench for axis_stream_sink_checker against a
// queue-based reference model, compared on every falling clock edge.
module tb_axis_stream_sink_checker;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int PKT   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic [W-1:0] tdata = '0;
  logic [W/8-1:0] tstrb = '1;
  logic        tlast = 1'b0;
  logic        tready;
  logic        rd_en = 1'b0;
  logic [W-1:0] rd_data;
  logic        rd_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0] pkt_count, err_count;
  logic        err_seq, err_len;
  logic        clr = 1'b0;

  int checks = 0;
  int errors = 0;

  axis_stream_sink_checker #(
    .C_S_AXIS_TDATA_WIDTH(W),
    .FIFO_DEPTH(DEPTH),
    .PKT_WORDS(PKT)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .fifo_count(fifo_count),
    .pkt_count(pkt_count),
    .err_count(err_count),
    .err_seq(err_seq),
    .err_len(err_len),
    .clr_err(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, checker as position-within-packet.
  logic [W-1:0] mq[$];
  int m_pos = 0, m_pkt = 0, m_err = 0;
  bit m_seq = 0, m_len = 0, m_tready = 0;

  always @(posedge clk) begin
    bit acc, pop, se, le;
    if (rst) begin
      mq.delete();
      m_pos = 0; m_pkt = 0; m_err = 0;
      m_seq = 0; m_len = 0; m_tready = 0;
    end else begin
      acc = tvalid && m_tready;
      pop = rd_en && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (clr) begin m_err = 0; m_seq = 0; m_len = 0; end
      if (acc) begin
        mq.push_back(tdata);
        se = (tdata != W'(m_pos + 1));
        le = (tlast != (m_pos == PKT - 1));
        if ((se || le) && m_err < 65535) m_err = m_err + 1;
        m_seq = m_seq | se;
        m_len = m_len | le;
        if (tlast && m_pkt < 65535) m_pkt = m_pkt + 1;
        m_pos = (tlast || m_pos == PKT - 1) ? 0 : m_pos + 1;
      end
      m_tready = (mq.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    chk("tready", tready, m_tready);
    chk("rd_valid", rd_valid, mq.size() > 0);
    chk("rd_data", rd_data, (mq.size() > 0) ? mq[0] : 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("pkt_count", pkt_count, m_pkt);
    chk("err_count", err_count, m_err);
    chk("err_seq", err_seq, m_seq);
    chk("err_len", err_len, m_len);
  end

  // Present one beat from a falling edge and return on the falling edge after it is taken.
  task automatic drive(input logic [W-1:0] d, input logic l);
    int n = 0;
    tvalid = 1'b1; tdata = d; tlast = l;
    while (!tready && n < 100) begin
      rd_en = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout: beat %0h not accepted within 100 cycles", d);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0; tlast = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input int nwords, input int last_at, input int bad_at, input logic [W-1:0] bad_val);
    for (int i = 0; i < nwords; i++)
      drive((i == bad_at) ? bad_val : W'(i + 1), i == last_at);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, pos;
    logic [W-1:0] d;
    logic l;

    #1;
    chk("reset_tready", tready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_fifo_count", fifo_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", tready, 1);

    // Continuous drain
    rd_en = 1'b1;
    send_pkt(8, 7, -1, '0);
    idle(3);
    chk("drain_pkt_count", pkt_count, 1);
    chk("drain_err_count", err_count, 0);
    chk("drain_flags", {err_seq, err_len}, 0);
    chk("drain_empty", fifo_count, 0);

    // Backpressure
    rd_en = 1'b0;
    send_pkt(8, 7, -1, '0);
    tvalid = 1'b1; tdata = 1; tlast = 1'b0;
    chk("bp_full_count", fifo_count, 8);
    chk("bp_full_tready", tready, 0);
    @(negedge clk);
    chk("bp_still_blocked", tready, 0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("bp_tready_after_pop", tready, 1);
    chk("bp_count_after_pop", fifo_count, 7);
    @(negedge clk);
    chk("bp_beat9_accepted", fifo_count, 8);
    rd_en = 1'b1;
    for (int i = 1; i < 8; i++) drive(W'(i + 1), i == 7);
    idle(12);
    chk("bp_pkt_count", pkt_count, 3);
    chk("bp_err_count", err_count, 0);

    // Sequence error
    send_pkt(8, 7, 3, 9);
    idle(2);
    chk("seq_err_seq", err_seq, 1);
    chk("seq_err_count", err_count, 1);
    chk("seq_err_len", err_len, 0);
    chk("seq_pkt_count", pkt_count, 4);
    pulse_clr();
    chk("clr_count", err_count, 0);
    chk("clr_flags", {err_seq, err_len}, 0);

    // Early TLAST then a good packet
    send_pkt(5, 4, -1, '0);
    send_pkt(8, 7, -1, '0);
    idle(2);
    chk("early_err_len", err_len, 1);
    chk("early_err_count", err_count, 1);
    chk("early_err_seq", err_seq, 0);
    chk("early_pkt_count", pkt_count, 6);
    pulse_clr();

    // Missing TLAST then a good packet
    send_pkt(8, -1, -1, '0);
    send_pkt(8, 7, -1, '0);
    idle(2);
    chk("missing_err_len", err_len, 1);
    chk("missing_err_count", err_count, 1);
    chk("missing_err_seq", err_seq, 0);
    chk("missing_pkt_count", pkt_count, 7);
    pulse_clr();
    idle(10);

    // Randomised traffic with occasional corruption
    pos = 0;
    repeat (600) begin
      rd_en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        d = W'(pos + 1);
        if ($urandom_range(0, 9) == 0) d = $urandom;
        l = (pos == PKT - 1);
        if ($urandom_range(0, 11) == 0) l = !l;
        drive(d, l);
        pos = (l || pos == PKT - 1) ? 0 : pos + 1;
      end
    end
    clr = 1'b0;
    rd_en = 1'b1;
    idle(12);

    // Reset mid-packet, then error/clear collision
    rd_en = 1'b0;
    send_pkt(3, -1, -1, '0);
    #2;
    rst = 1'b1;
    tvalid = 1'b0;
    #1;
    chk("midrst_tready", tready, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = pkt_count;
    chk("midrst_pkt_cleared", base, 0);
    rd_en = 1'b1;
    drive(7, 1'b0);
    chk("pre_collision_count", err_count, 1);
    clr = 1'b1;
    drive(9, 1'b1);
    clr = 1'b0;
    idle(2);
    chk("collision_err_seq", err_seq, 1);
    chk("collision_err_len", err_len, 1);
    chk("collision_err_count", err_count, 1);
    chk("collision_pkt_count", pkt_count, 1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
